// File: rtl/dma_bus_pkg.sv
// Shared types and constants for the DMA bus slave: state encoding,
// data width and the default timeout/counter sizing.
package dma_bus_pkg;
    localparam int DATA_W          = 32;
    localparam int TIMEOUT_CYC_DEF = 1024;
    localparam int CNT_W_DEF       = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WR    = 3'd1,
        ST_RD    = 3'd2,
        ST_ACK   = 3'd3,
        ST_ABORT = 3'd4
    } state_e;
endpackage

// File: rtl/bus_slave_timeout.sv
// Idle-cycle watchdog: counts enabled cycles, flags the cycle in which the
// count reaches TIMEOUT_CYC so the FSM can leave on that same edge.
module bus_slave_timeout #(
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic clr_i,
    output logic expired_o
);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [TW-1:0] cnt_q, cnt_d;

    assign expired_o = en_i && !clr_i && (cnt_q == TW'(TIMEOUT_CYC - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)     cnt_d = '0;
        else if (en_i) cnt_d = cnt_q + TW'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end
endmodule

// File: rtl/dma_bus_slave.sv
// Handshaked bus slave bridging a strobe-framed master transaction onto a
// write-FIFO push port and a first-word-fall-through read-FIFO pop port.
module dma_bus_slave
    import dma_bus_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic              wb_clk_2x,
    input  logic              wb_rst_n,
    input  logic              stb,
    input  logic              we,
    input  logic              m_rdy,
    output logic              s_rdy,
    input  logic [DATA_W-1:0] dat_i,
    output logic [DATA_W-1:0] dat_o,
    output logic              ack,
    output logic              abort,
    output logic [DATA_W-1:0] wr_data,
    output logic              wr_en,
    input  logic              wr_full,
    input  logic [DATA_W-1:0] rd_data,
    output logic              rd_en,
    input  logic              rd_empty,
    output logic [CNT_W-1:0]  xfer_cnt
);
    state_e             state_q, state_d;
    logic               rd_vld_q, rd_vld_d;
    logic [DATA_W-1:0]  dat_o_q, dat_o_d;
    logic [DATA_W-1:0]  wr_data_q, wr_data_d;
    logic               wr_pend_q, wr_pend_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               in_xact, xfer, rd_load, tmo_exp;

    assign in_xact = (state_q == ST_WR) || (state_q == ST_RD);

    bus_slave_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_tmo (
        .clk_i     (wb_clk_2x),
        .rst_ni    (wb_rst_n),
        .en_i      (in_xact && !xfer),
        .clr_i     (!in_xact || xfer),
        .expired_o (tmo_exp)
    );

    always_comb begin
        s_rdy = 1'b0;
        case (state_q)
            ST_WR:   s_rdy = !wr_full;
            ST_RD:   s_rdy = rd_vld_q;
            default: s_rdy = 1'b0;
        endcase
        xfer = m_rdy && s_rdy;
        // No pop on the closing/expiring cycle: that word would only be discarded.
        rd_load = (state_q == ST_RD) && stb && !tmo_exp && !rd_empty
                  && (!rd_vld_q || m_rdy);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (stb) state_d = we ? ST_WR : ST_RD;
            ST_WR,
            ST_RD: begin
                if (!stb)        state_d = ST_ACK;
                else if (tmo_exp) state_d = ST_ABORT;
            end
            ST_ACK:   state_d = ST_IDLE;
            ST_ABORT: if (!stb) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if ((state_q == ST_IDLE) && stb) cnt_d = '0;
        else if (xfer)                   cnt_d = cnt_q + CNT_W'(1);

        // A pushed word waits in wr_data while the FIFO is full; s_rdy is low
        // then, so a second word can never overwrite it.
        wr_pend_d = ((state_q == ST_WR) && xfer) || (wr_pend_q && wr_full);
        wr_data_d = ((state_q == ST_WR) && xfer) ? dat_i : wr_data_q;

        rd_vld_d = rd_vld_q;
        if (state_d != ST_RD) rd_vld_d = 1'b0;
        else if (rd_load)     rd_vld_d = 1'b1;
        else if (xfer)        rd_vld_d = 1'b0;
        dat_o_d = rd_load ? rd_data : dat_o_q;
    end

    always_ff @(posedge wb_clk_2x or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_q   <= ST_IDLE;
            rd_vld_q  <= 1'b0;
            dat_o_q   <= '0;
            wr_data_q <= '0;
            wr_pend_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            rd_vld_q  <= rd_vld_d;
            dat_o_q   <= dat_o_d;
            wr_data_q <= wr_data_d;
            wr_pend_q <= wr_pend_d;
            cnt_q     <= cnt_d;
        end
    end

    assign dat_o    = dat_o_q;
    assign wr_data  = wr_data_q;
    assign wr_en    = wr_pend_q && !wr_full;
    assign rd_en    = rd_load;
    assign ack      = (state_q == ST_ACK);
    assign abort    = (state_q == ST_ABORT);
    assign xfer_cnt = cnt_q;
endmodule

// File: tb/tb_dma_bus_slave.sv
// Randomized scenario bench for dma_bus_slave with a queue-based master/FIFO
// reference model; timeout shortened to 16 cycles.
module tb_dma_bus_slave;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        stb, we, m_rdy, s_rdy;
    logic [31:0] dat_i, dat_o, wr_data, rd_data;
    logic        ack, abort, wr_en, wr_full, rd_en, rd_empty;
    logic [15:0] xfer_cnt;

    int vectors = 0;
    int miscompares = 0;

    dma_bus_slave #(.TIMEOUT_CYC(16), .CNT_W(16)) dut (
        .wb_clk_2x(clk), .wb_rst_n(rst_n), .stb(stb), .we(we), .m_rdy(m_rdy),
        .s_rdy(s_rdy), .dat_i(dat_i), .dat_o(dat_o), .ack(ack), .abort(abort),
        .wr_data(wr_data), .wr_en(wr_en), .wr_full(wr_full), .rd_data(rd_data),
        .rd_en(rd_en), .rd_empty(rd_empty), .xfer_cnt(xfer_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; stb = 0; we = 0; m_rdy = 0; dat_i = '0;
        wr_full = 0; rd_empty = 1; rd_data = '0;
        #12;
        vectors++; if (s_rdy !== 1'b0)    begin miscompares++; $display("FAIL rst_s_rdy: got %b want 0", s_rdy); end
        vectors++; if (ack !== 1'b0)      begin miscompares++; $display("FAIL rst_ack: got %b want 0", ack); end
        vectors++; if (abort !== 1'b0)    begin miscompares++; $display("FAIL rst_abort: got %b want 0", abort); end
        vectors++; if (wr_en !== 1'b0)    begin miscompares++; $display("FAIL rst_wr_en: got %b want 0", wr_en); end
        vectors++; if (rd_en !== 1'b0)    begin miscompares++; $display("FAIL rst_rd_en: got %b want 0", rd_en); end
        vectors++; if (dat_o !== 32'h0)   begin miscompares++; $display("FAIL rst_dat_o: got %h want 0", dat_o); end
        vectors++; if (wr_data !== 32'h0) begin miscompares++; $display("FAIL rst_wr_data: got %h want 0", wr_data); end
        vectors++; if (xfer_cnt !== 16'h0) begin miscompares++; $display("FAIL rst_xfer_cnt: got %0d want 0", xfer_cnt); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        step();
    endtask

    // Master writes n words; every transferred word must reach the FIFO
    // exactly once, in order, never while full, one cycle after transfer.
    task automatic do_write(input int n, input bit stall);
        logic [31:0] words[$];
        int sent, pushed, cyc, idle;
        logic exp_push;
        for (int i = 0; i < n; i++) words.push_back(stall ? $urandom : 32'h11111111 * (i + 1));
        stb = 1; we = 1; m_rdy = 0; wr_full = 0; rd_empty = 1; dat_i = $urandom;
        #1;
        vectors++; if (s_rdy !== 1'b0) begin miscompares++; $display("FAIL wr_idle_s_rdy: got %b want 0", s_rdy); end
        step();
        sent = 0; pushed = 0; cyc = 0; idle = 0;
        while (sent < n && cyc < 200) begin
            m_rdy   = stall ? (idle >= 8 || $urandom_range(3) != 0) : 1'b1;
            wr_full = stall && ((cyc >= 3 && cyc < 6) || (cyc >= 6 && idle < 8 && $urandom_range(4) == 0));
            dat_i   = m_rdy ? words[sent] : $urandom;
            #1;
            vectors++; if (s_rdy !== !wr_full) begin miscompares++; $display("FAIL wr_s_rdy: got %b want %b", s_rdy, !wr_full); end
            exp_push = (sent > pushed) && !wr_full;
            vectors++; if (wr_en !== exp_push) begin miscompares++; $display("FAIL wr_en: got %b want %b (cyc %0d)", wr_en, exp_push, cyc); end
            if (wr_en === 1'b1 && sent > pushed) begin
                vectors++; if (wr_data !== words[pushed]) begin miscompares++; $display("FAIL wr_data: got %h want %h", wr_data, words[pushed]); end
                pushed++;
            end
            if (m_rdy && !wr_full) begin sent++; idle = 0; end else idle++;
            step(); cyc++;
        end
        vectors++; if (sent != n) begin miscompares++; $display("FAIL wr_budget: sent %0d want %0d", sent, n); end
        stb = 0; m_rdy = 0; wr_full = 0;
        #1;
        exp_push = sent > pushed;
        vectors++; if (wr_en !== exp_push) begin miscompares++; $display("FAIL wr_en_tail: got %b want %b", wr_en, exp_push); end
        if (wr_en === 1'b1 && sent > pushed) begin
            vectors++; if (wr_data !== words[pushed]) begin miscompares++; $display("FAIL wr_data_tail: got %h want %h", wr_data, words[pushed]); end
            pushed++;
        end
        step();
        vectors++; if (ack !== 1'b1) begin miscompares++; $display("FAIL wr_ack: got %b want 1", ack); end
        vectors++; if (xfer_cnt !== 16'(n)) begin miscompares++; $display("FAIL wr_xfer_cnt: got %0d want %0d", xfer_cnt, n); end
        vectors++; if (wr_en !== 1'b0) begin miscompares++; $display("FAIL wr_en_ack: got %b want 0", wr_en); end
        step();
        vectors++; if (ack !== 1'b0) begin miscompares++; $display("FAIL wr_ack_len: got %b want 0", ack); end
        vectors++; if (pushed != n) begin miscompares++; $display("FAIL wr_push_count: got %0d want %0d", pushed, n); end
    endtask

    // mode 0: m_rdy toggles 1,0,1,0; mode 1: random m_rdy and FIFO gaps;
    // mode 2: m_rdy held high with a never-empty FIFO.
    task automatic do_read(input int n, input int mode);
        logic [31:0] words[$], fifo[$];
        logic [31:0] prev_dat;
        logic prev_hold, prev_fill, exp_rd_en;
        int got, cyc, idle;
        for (int i = 0; i < n; i++) words.push_back($urandom);
        fifo = words;
        stb = 1; we = 0; m_rdy = 0; wr_full = 0; rd_empty = 0; rd_data = fifo[0];
        #1;
        vectors++; if (s_rdy !== 1'b0 || rd_en !== 1'b0) begin miscompares++; $display("FAIL rd_idle: got s_rdy %b rd_en %b want 0 0", s_rdy, rd_en); end
        step();
        got = 0; cyc = 0; idle = 0; prev_hold = 0; prev_fill = 0; prev_dat = '0;
        while (got < n && cyc < 300) begin
            case (mode)
                0:       m_rdy = (cyc % 2 == 0);
                1:       m_rdy = (idle >= 8) || ($urandom_range(1) == 1);
                default: m_rdy = 1'b1;
            endcase
            rd_empty = (fifo.size() == 0) || (mode == 1 && idle < 8 && $urandom_range(3) == 0);
            rd_data  = (fifo.size() != 0) ? fifo[0] : $urandom;
            #1;
            if (prev_hold) begin
                vectors++; if (s_rdy !== 1'b1 || dat_o !== prev_dat) begin miscompares++; $display("FAIL rd_hold: got %b/%h want 1/%h", s_rdy, dat_o, prev_dat); end
            end
            if (prev_fill) begin
                vectors++; if (s_rdy !== 1'b1) begin miscompares++; $display("FAIL rd_fill: got s_rdy %b want 1", s_rdy); end
            end
            exp_rd_en = !rd_empty && (!s_rdy || m_rdy);
            vectors++; if (rd_en !== exp_rd_en) begin miscompares++; $display("FAIL rd_en: got %b want %b (cyc %0d)", rd_en, exp_rd_en, cyc); end
            if (m_rdy && s_rdy === 1'b1) begin
                vectors++; if (dat_o !== words[got]) begin miscompares++; $display("FAIL rd_data: got %h want %h", dat_o, words[got]); end
                got++; idle = 0;
            end else idle++;
            prev_hold = (s_rdy === 1'b1) && !m_rdy;
            prev_dat  = dat_o;
            prev_fill = (rd_en === 1'b1);
            if (rd_en === 1'b1 && fifo.size() != 0) void'(fifo.pop_front());
            step(); cyc++;
        end
        vectors++; if (got != n) begin miscompares++; $display("FAIL rd_budget: got %0d want %0d", got, n); end
        if (mode == 2) begin
            vectors++; if (cyc != n + 1) begin miscompares++; $display("FAIL rd_b2b_cycles: got %0d want %0d", cyc, n + 1); end
        end
        stb = 0; m_rdy = 0; rd_empty = 1;
        #1;
        vectors++; if (rd_en !== 1'b0) begin miscompares++; $display("FAIL rd_en_close: got %b want 0", rd_en); end
        step();
        vectors++; if (ack !== 1'b1) begin miscompares++; $display("FAIL rd_ack: got %b want 1", ack); end
        vectors++; if (xfer_cnt !== 16'(n)) begin miscompares++; $display("FAIL rd_xfer_cnt: got %0d want %0d", xfer_cnt, n); end
        vectors++; if (s_rdy !== 1'b0) begin miscompares++; $display("FAIL rd_s_rdy_ack: got %b want 0", s_rdy); end
        step();
        vectors++; if (ack !== 1'b0) begin miscompares++; $display("FAIL rd_ack_len: got %b want 0", ack); end
    endtask

    task automatic test_write_burst();  do_write(4, 1'b0);  endtask
    task automatic test_write_stall();  do_write(12, 1'b1); endtask
    task automatic test_read_toggle();  do_read(3, 0);      endtask
    task automatic test_read_random();  do_read(20, 1);     endtask
    task automatic test_back_to_back(); do_read(8, 2);      endtask

    task automatic test_timeout();
        stb = 1; we = 0; m_rdy = 0; rd_empty = 1; wr_full = 0;
        step();
        for (int c = 1; c <= 20; c++) begin
            #1;
            vectors++; if (abort !== (c >= 17)) begin miscompares++; $display("FAIL tmo_abort: got %b want %b (c %0d)", abort, (c >= 17), c); end
            vectors++; if (ack !== 1'b0 || rd_en !== 1'b0 || s_rdy !== 1'b0) begin miscompares++; $display("FAIL tmo_quiet: got ack %b rd_en %b s_rdy %b want 0 0 0", ack, rd_en, s_rdy); end
            step();
        end
        stb = 0;
        #1;
        vectors++; if (abort !== 1'b1) begin miscompares++; $display("FAIL tmo_abort_hold: got %b want 1", abort); end
        step();
        vectors++; if (abort !== 1'b0 || ack !== 1'b0) begin miscompares++; $display("FAIL tmo_exit: got abort %b ack %b want 0 0", abort, ack); end
        vectors++; if (xfer_cnt !== 16'h0) begin miscompares++; $display("FAIL tmo_xfer_cnt: got %0d want 0", xfer_cnt); end
    endtask

    task automatic test_timeout_vs_stb();
        stb = 1; we = 0; m_rdy = 0; rd_empty = 1;
        step();
        for (int c = 1; c <= 16; c++) begin
            if (c == 16) stb = 0;
            #1;
            vectors++; if (abort !== 1'b0) begin miscompares++; $display("FAIL race_abort: got %b want 0 (c %0d)", abort, c); end
            step();
        end
        vectors++; if (ack !== 1'b1 || abort !== 1'b0) begin miscompares++; $display("FAIL race_ack: got ack %b abort %b want 1 0", ack, abort); end
        step();
        vectors++; if (ack !== 1'b0 || abort !== 1'b0) begin miscompares++; $display("FAIL race_idle: got ack %b abort %b want 0 0", ack, abort); end
    endtask

    task automatic test_reset_mid();
        stb = 1; we = 1; m_rdy = 0; wr_full = 0; rd_empty = 1;
        step();
        for (int i = 0; i < 2; i++) begin
            m_rdy = 1; dat_i = $urandom;
            step();
        end
        dat_i = $urandom;
        #1;
        rst_n = 1'b0;
        #1;
        vectors++; if (s_rdy !== 1'b0)     begin miscompares++; $display("FAIL mid_s_rdy: got %b want 0", s_rdy); end
        vectors++; if (wr_en !== 1'b0)     begin miscompares++; $display("FAIL mid_wr_en: got %b want 0", wr_en); end
        vectors++; if (wr_data !== 32'h0)  begin miscompares++; $display("FAIL mid_wr_data: got %h want 0", wr_data); end
        vectors++; if (xfer_cnt !== 16'h0) begin miscompares++; $display("FAIL mid_xfer_cnt: got %0d want 0", xfer_cnt); end
        vectors++; if (ack !== 1'b0 || abort !== 1'b0 || rd_en !== 1'b0) begin miscompares++; $display("FAIL mid_ctl: got ack %b abort %b rd_en %b want 0 0 0", ack, abort, rd_en); end
        step();
        stb = 0; m_rdy = 0; rst_n = 1'b1;
        step();
        vectors++; if (ack !== 1'b0 || abort !== 1'b0) begin miscompares++; $display("FAIL mid_post: got ack %b abort %b want 0 0", ack, abort); end
        do_write(3, 1'b0);
    endtask

    initial begin
        test_reset();
        test_write_burst();
        test_write_stall();
        test_read_toggle();
        test_read_random();
        test_back_to_back();
        test_timeout();
        test_timeout_vs_stb();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/dma_bus_slave.md
DMA_BUS_SLAVE -- requirements
Module: dma_bus_slave

Interface
REQ-001 Parameter TIMEOUT_CYC, default 1024: idle cycles with no word transfer, while a transaction is open, before abort.
REQ-002 Parameter CNT_W, default 16: width of xfer_cnt.
REQ-003 wb_clk_2x  in  1  sole clock; all logic on its rising edge.
REQ-004 wb_rst_n  in  1  reset; asynchronous assert, active-low.
REQ-005 stb  in  1  master transaction strobe, held high for the whole transaction.
REQ-006 we  in  1  direction, sampled only at transaction start: 1 = write (master to slave), 0 = read.
REQ-007 m_rdy  in  1  write: dat_i valid; read: master accepts dat_o.
REQ-008 s_rdy  out  1  write: slave accepts dat_i; read: dat_o valid.
REQ-009 dat_i  in  32  write data from master.
REQ-010 dat_o  out  32  read data to master, registered.
REQ-011 ack  out  1  one-cycle pulse on normal transaction close.
REQ-012 abort  out  1  high while the transaction is timed out.
REQ-013 wr_data  out  32; wr_en  out  1; wr_full  in  1  write-FIFO push port.
REQ-014 rd_data  in  32; rd_en  out  1; rd_empty  in  1  read-FIFO pop port, first-word-fall-through.
REQ-015 xfer_cnt  out  CNT_W  words transferred in the current or last transaction.

Function
REQ-016 States: IDLE, WR, RD, ACK, ABORT.
REQ-017 IDLE with stb=1: go to WR if we=1, else RD; clear xfer_cnt and the timeout counter.
REQ-018 A word transfers in a cycle only when m_rdy=1 and s_rdy=1.
REQ-019 WR: s_rdy = !wr_full (combinational); each transfer registers dat_i into wr_data and pulses wr_en one cycle later (latency 1).
REQ-020 RD: dat_o/s_rdy form a one-entry output register; it loads rd_data with rd_en=1 when rd_empty=0 and (s_rdy=0 or m_rdy=1); otherwise dat_o and s_rdy hold.
REQ-021 RD back-to-back: with rd_empty=0 and m_rdy held 1, one word per cycle after the first fill cycle.
REQ-022 xfer_cnt increments by one per transfer and wraps modulo 2^CNT_W.
REQ-023 Timeout counter increments each WR/RD cycle without a transfer, clears on every transfer, and reaching TIMEOUT_CYC moves the block to ABORT.
REQ-024 WR/RD with stb=0: go to ACK; stb drop takes priority over a simultaneous timeout.
REQ-025 ACK: ack=1 for exactly that cycle; next state IDLE; stb is not evaluated in ACK.
REQ-026 ABORT: abort=1; s_rdy=0; rd_en=0; stay until stb=0, then IDLE; no ack is issued.
REQ-027 On leaving RD, an unconsumed word in the output register is discarded: s_rdy clears and the word is not counted.
REQ-028 In IDLE, ACK and ABORT: s_rdy=0 and rd_en=0; wr_en=0, except the one trailing wr_en pulse from a final-cycle write transfer.
REQ-029 wr_en and rd_en never assert when wr_full or rd_empty, respectively, are asserted.

Reset
REQ-030 wb_rst_n=0 forces IDLE asynchronously: s_rdy, ack, abort, wr_en, rd_en = 0; dat_o, wr_data, xfer_cnt, timeout counter = 0.
REQ-031 Reset mid-transaction drops in-flight words without ack or abort; the first post-reset transaction needs stb sampled in IDLE.

Structure
REQ-032 Package dma_bus_pkg holds the state enumeration, the 32-bit data-width constant and the TIMEOUT_CYC/CNT_W defaults.
REQ-033 Sub-module bus_slave_timeout holds the timeout counter (inputs: enable, clear; output: expired).
REQ-034 The FSM, WR datapath and RD output register stay in dma_bus_slave.

Verification
REQ-035 Write 4 words (0x11111111..0x44444444), m_rdy=1, wr_full=0 -> 4 wr_en pulses, each 1 cycle after its transfer, in order; after stb drops: ack pulse, xfer_cnt=4.
REQ-036 Write with wr_full=1 for 3 cycles mid-burst -> s_rdy=0 and no wr_en during the stall; no word lost or duplicated; xfer_cnt matches the words sent.
REQ-037 Read 3 FIFO words with m_rdy toggling 1,0,1,0 -> dat_o held stable while m_rdy=0; master receives exactly the 3 words in order; xfer_cnt=3.
REQ-038 Read, rd_empty=1, stb held, TIMEOUT_CYC=16 -> abort rises 16 cycles after RD entry and holds until stb drops; no ack; IDLE next cycle.
REQ-039 stb drop in the same cycle as timeout expiry -> ack pulse, abort stays 0.
REQ-040 wb_rst_n asserted mid-write burst -> all outputs 0 immediately; a fresh transaction after release completes with correct xfer_cnt.
